// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants and types for the RV32M multiply/divide unit
// Contents: M-extension opcode/funct7 match values, funct3 operation enum,
//           FSM state encoding.
package muldiv_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_MUL  = 2'd1;
  localparam state_t S_DIV  = 2'd2;
  localparam state_t S_DONE = 2'd3;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one iteration of shift-add multiply or restoring divide
// Ports: mode_div_i selects divide; acc_i/acc_o 64-bit accumulator
//        (multiply: {hi, multiplier/low product}; divide: {unused, dividend/quotient});
//        rem_i/rem_o 33-bit partial remainder; opnd_i multiplicand or divisor magnitude.
module muldiv_step (
  input  logic        mode_div_i,
  input  logic [63:0] acc_i,
  input  logic [32:0] rem_i,
  input  logic [31:0] opnd_i,
  output logic [63:0] acc_o,
  output logic [32:0] rem_o
);

  logic [32:0] mul_sum;
  logic [32:0] shifted;
  logic [33:0] diff;
  logic        unused_rem_msb;

  // The remainder never exceeds the divisor, so its top bit is always zero
  // before the shift.
  assign unused_rem_msb = rem_i[32];

  always_comb begin
    mul_sum = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, opnd_i} : 33'd0);
    shifted = {rem_i[31:0], acc_i[31]};
    diff    = {1'b0, shifted} - {2'b00, opnd_i};
    if (mode_div_i) begin
      // diff[33] set means the trial subtract borrowed: keep the old remainder.
      acc_o = {acc_i[63:32], acc_i[30:0], ~diff[33]};
      rem_o = diff[33] ? shifted : diff[32:0];
    end else begin
      // Add the multiplicand into the high half when the current multiplier
      // bit is set, then shift the whole product right one place.
      acc_o = {mul_sum, acc_i[31:1]};
      rem_o = rem_i;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M multiply/divide unit in the EX stage
// Ports: clk, rst (sync, active-high); valid_i/inst_i/rs1_i/rs2_i from ID/EX;
//        flush_i squashes any in-flight op; stall_o freezes the front end;
//        done_o qualifies the registered result_o.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] opnd_q, opnd_d;
  funct3_e     op_q, op_d;
  logic        neg_q, neg_d;
  logic [31:0] result_q, result_d;

  funct3_e     f3;
  logic        start;
  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        div_zero, div_ovf;
  logic [31:0] special_res;
  logic [63:0] step_acc;
  logic [32:0] step_rem;
  logic [63:0] mul_fix;
  logic [31:0] div_val, div_fix, final_res;
  logic        unused_bits;

  assign unused_bits = ^{inst_i[24:15], inst_i[11:7], step_rem[32]};

  assign f3    = funct3_e'(inst_i[14:12]);
  assign start = valid_i && (inst_i[6:0] == OPCODE_OP) && (inst_i[31:25] == FUNCT7_MULDIV)
                 && (state_q == S_IDLE) && !flush_i;

  assign a_signed = (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  assign b_signed = (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  assign a_neg    = a_signed && rs1_i[31];
  assign b_neg    = b_signed && rs2_i[31];
  assign a_mag    = a_neg ? (32'd0 - rs1_i) : rs1_i;
  assign b_mag    = b_neg ? (32'd0 - rs2_i) : rs2_i;

  // Divides whose result is architecturally fixed finish without iterating.
  assign div_zero = f3[2] && (rs2_i == 32'd0);
  assign div_ovf  = f3[2] && !f3[0] && (rs1_i == 32'h8000_0000) && (rs2_i == 32'hFFFF_FFFF);
  always_comb begin
    special_res = 32'd0;
    if (div_zero)     special_res = f3[1] ? rs1_i : 32'hFFFF_FFFF;
    else if (div_ovf) special_res = f3[1] ? 32'd0 : 32'h8000_0000;
  end

  muldiv_step u_step (
    .mode_div_i (state_q == S_DIV),
    .acc_i      (acc_q),
    .rem_i      (rem_q),
    .opnd_i     (opnd_q),
    .acc_o      (step_acc),
    .rem_o      (step_rem)
  );

  // Sign correction is applied to the last step's output so that the
  // registered result is already final on the cycle done_o rises.
  always_comb begin
    mul_fix   = neg_q ? (64'd0 - step_acc) : step_acc;
    div_val   = op_q[1] ? step_rem[31:0] : step_acc[31:0];
    div_fix   = neg_q ? (32'd0 - div_val) : div_val;
    final_res = (state_q == S_DIV) ? div_fix
              : ((op_q == F3_MUL) ? mul_fix[31:0] : mul_fix[63:32]);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opnd_d   = opnd_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = f3;
          // Quotient/product sign is the XOR of operand signs; remainder and
          // MULHSU follow rs1 alone (b_neg is 0 for MULHSU).
          neg_d = (f3 == F3_REM) ? a_neg : (a_neg ^ b_neg);
          cnt_d = 5'd0;
          if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = S_DONE;
          end else if (f3[2]) begin
            acc_d   = {32'd0, a_mag};
            rem_d   = 33'd0;
            opnd_d  = b_mag;
            state_d = S_DIV;
          end else begin
            acc_d   = {32'd0, b_mag};
            rem_d   = 33'd0;
            opnd_d  = a_mag;
            state_d = S_MUL;
          end
        end
      end
      S_MUL, S_DIV: begin
        acc_d = step_acc;
        rem_d = step_rem;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          result_d = final_res;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) begin
      state_d  = S_IDLE;
      cnt_d    = 5'd0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      rem_q    <= 33'd0;
      opnd_q   <= 32'd0;
      op_q     <= F3_MUL;
      neg_q    <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opnd_q   <= opnd_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign stall_o  = start || (state_q == S_MUL) || (state_q == S_DIV);
  assign done_o   = (state_q == S_DONE) && !flush_i;
  assign result_o = result_q;

endmodule
